log_mem_reader: RTL

//  Drains the capture log memory once it reports full. Sweeps read addresses 0..N_WORDS-1 and

---
 rtl/log_pkg.sv | 17 +
 rtl/word_serializer.sv | 69 ++++++
 rtl/log_mem_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared log memory constants and reader state encoding
package log_pkg;

   localparam int NB_BYTE        = 8;
   localparam int NB_ADD_MEM_DEF = 14;
   localparam int NB_DATA_DEF    = 32;
   localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } log_state_e;

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-load word to MSB-first valid/ready byte stream
module word_serializer
   import log_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_word,
   output logic [NB_BYTE-1:0] o_tdata,
   output logic               o_tvalid,
   input  logic               i_tready,
   output logic               o_tlast
);

   localparam int                BPW      = NB_DATA / NB_BYTE;
   localparam int                NB_CNT   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

   logic [NB_DATA-1:0] shift_q, shift_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               accept;

   assign accept = valid_q && i_tready;

   // Shifting out consumed bytes leaves the register zero once the word is drained.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (i_clear) begin
         shift_d = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (i_load) begin
         shift_d = i_word;
         cnt_d   = '0;
         valid_d = 1'b1;
      end else if (accept) begin
         shift_d = shift_q << NB_BYTE;
         if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            valid_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign o_tdata  = shift_q[NB_DATA-1 -: NB_BYTE];
   assign o_tvalid = valid_q;
   assign o_tlast  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/log_mem_reader.sv
// rtl/log_mem_reader.sv - sweeps the full log memory and streams it out as bytes
module log_mem_reader
   import log_pkg::*;
#(
   parameter int NB_ADD_MEM = NB_ADD_MEM_DEF,
   parameter int N_WORDS    = 2**NB_ADD_MEM,
   parameter int RD_LATENCY = 2,
   parameter int NB_DATA    = NB_DATA_DEF
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_mem_full,
   input  logic [NB_DATA-1:0]    i_data_log,
   output logic                  o_read_log,
   output logic [NB_ADD_MEM-1:0] o_addr_log,
   output logic [NB_BYTE-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   // One bit wider than the address so N_WORDS == 2**NB_ADD_MEM stays representable.
   localparam logic [NB_ADD_MEM:0] LAST_IDX = (NB_ADD_MEM + 1)'(N_WORDS - 1);
   localparam logic [2:0]          LAT_LOAD = 3'(RD_LATENCY - 1);

   log_state_e            state_q, state_d;
   logic [NB_ADD_MEM-1:0] addr_q, addr_d;
   logic [2:0]            lat_q, lat_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ser_load, ser_clear, tx_last;
   logic                  in_transfer;

   assign in_transfer = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_SEND);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lat_d     = lat_q;
      ser_load  = 1'b0;
      ser_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start && i_mem_full) begin
               state_d = ST_ADDR;
               addr_d  = '0;
            end
         end
         ST_ADDR: begin
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               ser_load = 1'b1;
               state_d  = ST_SEND;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_SEND: begin
            if (o_tx_valid && i_tx_ready && tx_last) begin
               if ({1'b0, addr_q} == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_ADDR;
               end
            end
         end
         ST_DONE: begin
            addr_d  = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides any progress made this cycle, including a pending load.
      if (in_transfer && i_abort) begin
         state_d   = ST_DONE;
         ser_load  = 1'b0;
         ser_clear = 1'b1;
      end
      busy_d = (state_d == ST_ADDR) || (state_d == ST_WAIT) || (state_d == ST_SEND);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         lat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   word_serializer #(
      .NB_DATA (NB_DATA)
   ) u_ser (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_clear  (ser_clear),
      .i_load   (ser_load),
      .i_word   (i_data_log),
      .o_tdata  (o_tx_data),
      .o_tvalid (o_tx_valid),
      .i_tready (i_tx_ready),
      .o_tlast  (tx_last)
   );

   assign o_busy     = busy_q;
   assign o_read_log = busy_q;
   assign o_done     = done_q;
   assign o_addr_log = addr_q;

endmodule
